// File: rtl/md_ctrl.sv
// HI/LO multiply/divide scheduler: drives an external pipelined multiplier and runs an internal restoring divider.
// Optional compile-time macro MD_EARLY_EXIT_EN: finish a divide early when |divisor| > |dividend|.
module md_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_mult_en,
  input  logic        de_div_en,
  input  logic        de_is_signed,
  input  logic [31:0] de_MD_src1,
  input  logic [31:0] de_MD_src2,
  input  logic        de_md_read,
  input  logic        flush,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        md_busy,
  output logic        md_stall,
  output logic        wb_MD_complete,
  output logic [63:0] wb_MD_result
);

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_MAX   = (MUL_LAT > DIV_STEPS) ? MUL_LAT : DIV_STEPS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      dvs;
  logic             s1;
  logic             s2;
  logic             dvz;
  logic             early;

  logic             accept_mul;
  logic             accept_div;
  logic [31:0]      mag1;
  logic [31:0]      mag2;
  logic             early_hit;
  logic [32:0]      rem_sh;
  logic             ge;
  logic [31:0]      rem_next;
  logic [31:0]      quo_next;
  logic [31:0]      quo_fix;
  logic [31:0]      rem_fix;
  logic [31:0]      hi_early;

  // Acceptance only in IDLE; mult wins when both requests are present.
  assign accept_mul = (state == IDLE) && !flush && de_mult_en;
  assign accept_div = (state == IDLE) && !flush && !de_mult_en && de_div_en;

  assign mag1 = (de_is_signed && de_MD_src1[31]) ? 32'(-de_MD_src1) : de_MD_src1;
  assign mag2 = (de_is_signed && de_MD_src2[31]) ? 32'(-de_MD_src2) : de_MD_src2;

`ifdef MD_EARLY_EXIT_EN
  assign early_hit = (mag2 != 32'd0) && (mag2 > mag1);
`else
  assign early_hit = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  assign rem_sh   = {rem, quo[31]};
  assign ge       = rem_sh >= {1'b0, dvs};
  assign rem_next = ge ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
  assign quo_next = {quo[30:0], ge};

  // Divide-by-zero leaves |src1| in the remainder, so only the quotient needs forcing.
  assign quo_fix  = dvz ? 32'hFFFF_FFFF : ((s1 ^ s2) ? 32'(-quo) : quo);
  assign rem_fix  = s1 ? 32'(-rem) : rem;
  assign hi_early = s1 ? 32'(-quo) : quo;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_mul)      state_next = MUL;
        else if (accept_div) state_next = DIV;
      end
      MUL: begin
        if (flush)             state_next = IDLE;
        else if (cnt == '0)    state_next = DONE;
      end
      DIV: begin
        if (flush)                      state_next = IDLE;
        else if (early)                 state_next = DONE;
        else if (cnt == CNT_W'(1))      state_next = SIGN;
      end
      SIGN:    state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    md_busy  = 1'b0;
    md_stall = 1'b0;
    md_busy  = (state != IDLE);
    md_stall = md_busy & (de_md_read | de_mult_en | de_div_en);
  end

  // Datapath: operand capture, divider iteration and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      s1             <= 1'b0;
      s2             <= 1'b0;
      dvz            <= 1'b0;
      early          <= 1'b0;
      mul_start      <= 1'b0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_signed     <= 1'b0;
      wb_MD_complete <= 1'b0;
      wb_MD_result   <= '0;
    end else begin
      mul_start      <= 1'b0;
      wb_MD_complete <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept_mul) begin
            mul_a      <= de_MD_src1;
            mul_b      <= de_MD_src2;
            mul_signed <= de_is_signed;
            mul_start  <= 1'b1;
            cnt        <= CNT_W'(MUL_LAT);
          end else if (accept_div) begin
            s1    <= de_is_signed & de_MD_src1[31];
            s2    <= de_is_signed & de_MD_src2[31];
            quo   <= mag1;
            dvs   <= mag2;
            rem   <= '0;
            dvz   <= (de_MD_src2 == 32'd0);
            early <= early_hit;
            cnt   <= CNT_W'(DIV_STEPS);
          end
        end
        MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0 && !flush) wb_MD_result <= mul_result;
        end
        DIV: begin
          if (!early) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - CNT_W'(1);
          end else if (!flush) begin
            wb_MD_result <= {hi_early, 32'd0};
          end
        end
        SIGN: begin
          if (!flush) wb_MD_result <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: expected {HI,LO} and completion cycle queued at issue, checked on wb_MD_complete.
module tb_md_ctrl;

  localparam int unsigned MUL_LAT = 2;
`ifdef MD_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        de_mult_en, de_div_en, de_is_signed, de_md_read, flush;
  logic [31:0] de_MD_src1, de_MD_src2;
  logic        mul_start, mul_signed, md_busy, md_stall, wb_MD_complete;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result, wb_MD_result;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;
  logic [63:0] mpipe [MUL_LAT];
  logic [63:0] prod;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .de_mult_en(de_mult_en), .de_div_en(de_div_en), .de_is_signed(de_is_signed),
    .de_MD_src1(de_MD_src1), .de_MD_src2(de_MD_src2), .de_md_read(de_md_read),
    .flush(flush),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
    .mul_result(mul_result),
    .md_busy(md_busy), .md_stall(md_stall),
    .wb_MD_complete(wb_MD_complete), .wb_MD_result(wb_MD_result)
  );

  // External multiplier: product appears MUL_LAT cycles after mul_start, junk otherwise.
  always_comb begin
    if (mul_signed) prod = 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
    else            prod = {32'd0, mul_a} * {32'd0, mul_b};
  end
  always @(posedge clk) begin
    mpipe[0] <= mul_start ? prod : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wb_MD_complete) begin
      exp_t e;
      if (sbq.size() == 0) chk("spurious_complete", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("result", wb_MD_result, e.res);
        chk("complete_cycle", 64'(cyc), 64'(e.at));
        last_res = e.res;
      end
    end
  end

  task automatic model(input bit m, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat);
    int sa, sb;
`ifdef MD_EARLY_EXIT_EN
    logic [31:0] ma, mb;
`endif
    if (m) begin
      if (sg) res = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      else    res = {32'd0, a} * {32'd0, b};
      lat = 2 + int'(MUL_LAT);
    end else begin
      lat = 34;
      if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
      else if (sg) begin
        sa  = $signed(a);
        sb  = $signed(b);
        res = {32'(sa % sb), 32'(sa / sb)};
      end else res = {a % b, a / b};
`ifdef MD_EARLY_EXIT_EN
      ma = (sg && a[31]) ? 32'(-a) : a;
      mb = (sg && b[31]) ? 32'(-b) : b;
      if (b != 32'd0 && mb > ma) lat = 2;
`endif
    end
  endtask

  // Drive one request for a single cycle; optionally queue its expected completion.
  task automatic issue(input bit m, input bit d, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input bit want, input logic [63:0] res, input int lat);
    exp_t e;
    de_mult_en = m; de_div_en = d; de_is_signed = sg; de_MD_src1 = a; de_MD_src2 = b;
    if (want) begin
      e.res = res;
      e.at  = cyc + lat;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    de_mult_en = 1'b0; de_div_en = 1'b0;
  endtask

  task automatic issue_m(input bit m, input bit d, input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int lat;
    model(m, sg, a, b, r, lat);
    issue(m, d, sg, a, b, 1'b1, r, lat);
  endtask

  task automatic drain();
    int t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (sbq.size() != 0 && t < 80);
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    bit rm, rs;
    reset = 1'b1; flush = 1'b0; de_md_read = 1'b1; de_mult_en = 1'b1; de_div_en = 1'b0;
    de_is_signed = 1'b0; de_MD_src1 = '0; de_MD_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    chk("rst_mul", {mul_a, mul_b}, 64'd0);
    chk("rst_mul_ctl", {62'd0, mul_start, mul_signed}, 64'd0);
    chk("rst_wb", wb_MD_result, 64'd0);
    chk("rst_cmpl", 64'(wb_MD_complete), 64'd0);
    de_mult_en = 1'b0; de_md_read = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // multu with HI/LO read held: stall from N+1 through DONE, start pulse at N+1 only
    de_md_read = 1'b1;
    de_mult_en = 1'b1; de_is_signed = 1'b0; de_MD_src1 = 32'hFFFF_FFFF; de_MD_src2 = 32'hFFFF_FFFF;
    begin
      exp_t e;
      e.res = 64'hFFFF_FFFE_0000_0001;
      e.at  = cyc + 4;
      sbq.push_back(e);
    end
    @(negedge clk);
    chk("stall_n0", 64'(md_stall), 64'd0);
    @(posedge clk); #1;
    de_mult_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("stall_prof", 64'(md_stall), (k <= 4) ? 64'd1 : 64'd0);
      if (k == 1) begin
        chk("mul_start_n1", 64'(mul_start), 64'd1);
        chk("mul_ops", {mul_a, mul_b}, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (k == 2) chk("mul_start_n2", 64'(mul_start), 64'd0);
    end
    de_md_read = 1'b0;
    drain();

    // both requests: mult wins; a div request while busy is ignored
    issue_m(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5);
    de_div_en = 1'b1; de_MD_src1 = 32'd77; de_MD_src2 = 32'd3;
    @(posedge clk); #1;
    de_div_en = 1'b0;
    drain();
    issue_m(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    drain();

    // divides
    issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    drain();
    issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 1'b1, 64'h0000_0064_FFFF_FFFF, 34);
    drain();
    issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0, 1'b1, 64'hFFFF_FF9C_FFFF_FFFF, 34);
    drain();
    issue(1'b0, 1'b1, 1'b0, 32'd3, 32'd10, 1'b1, 64'h0000_0003_0000_0000, EARLY_LAT);
    drain();
    issue_m(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
    drain();
    issue_m(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd9);
    drain();
    issue_m(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    drain();

    for (int i = 0; i < 8; i++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = (rm || $urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 50));
      if (!rm && rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      issue_m(rm, !rm, rs, ra, rb);
      drain();
    end

    // div at N flushed at N+10; mult at N+11 accepted
    issue(1'b0, 1'b1, 1'b0, 32'd12345, 32'd7, 1'b0, 64'd0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("busy_pre_flush", 64'(md_busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("busy_post_flush", 64'(md_busy), 64'd0);
    issue_m(1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
    drain();

    // flush in IDLE blocks acceptance
    de_mult_en = 1'b1; flush = 1'b1; de_MD_src1 = 32'd9; de_MD_src2 = 32'd9;
    @(posedge clk); #1;
    de_mult_en = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(md_busy), 64'd0);

    // flush in the mul capture cycle discards the late product
    issue(1'b1, 1'b0, 1'b0, 32'd7, 32'd11, 1'b0, 64'd0, 0);
    repeat (MUL_LAT) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_mul_busy", 64'(md_busy), 64'd0);
    chk("flush_mul_hold", wb_MD_result, last_res);
    repeat (4) @(posedge clk);
    #1;
    chk("flush_mul_hold2", wb_MD_result, last_res);

    // flush during DONE does not cancel the completion
    issue_m(1'b1, 1'b0, 1'b0, 32'd5, 32'd9);
    repeat (MUL_LAT + 1) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();

    // reset mid-divide: back to IDLE, no completion
    issue(1'b0, 1'b1, 1'b0, 32'd1000, 32'd7, 1'b0, 64'd0, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(md_busy), 64'd0);
    chk("midrst_wb", wb_MD_result, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    issue_m(1'b0, 1'b1, 1'b0, 32'd1000, 32'd7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Scheduler for the HI/LO multiply/divide resource. It accepts mult/div requests from the decode stage, sequences an external fixed-latency pipelined multiplier, and runs an internal iterative 32-step shift-subtract divider. It drives the `wb_MD_complete`/`wb_MD_result` pair into decode's HI/LO write port. It also raises the stall that serialises MD ops and HI/LO accesses against an in-flight operation.

Parameters:
MUL_LAT, 2, cycles from mul_start to mul_result valid (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
de_mult_en  input  1  mult/multu request (already exception-gated by decode)
de_div_en  input  1  div/divu request (already exception-gated by decode)
de_is_signed  input  1  signed operation
de_MD_src1  input  32  rs operand (dividend / multiplicand)
de_MD_src2  input  32  rt operand (divisor / multiplier)
de_md_read  input  1  decode holds mfhi/mflo/mthi/mtlo
flush  input  1  exception/ERET flush: cancel in-flight op
mul_start  output  1  one-cycle start to external multiplier
mul_a  output  32  registered multiplier operand A
mul_b  output  32  registered multiplier operand B
mul_signed  output  1  registered signed flag
mul_result  input  64  product, valid MUL_LAT cycles after mul_start
md_busy  output  1  state != IDLE
md_stall  output  1  stall decode
wb_MD_complete  output  1  one-cycle result-valid pulse
wb_MD_result  output  64  {HI,LO}

Behaviour:
- States: IDLE, MUL, DIV, SIGN, DONE.
- Reset: state IDLE. Every output is 0: mul_*, wb_MD_complete, wb_MD_result, md_busy, md_stall.
- Request timing: a request is sampled in cycle N, in IDLE, with flush=0.
  - If mult and div are both asserted, mult wins.
  - Requests outside IDLE are ignored; decode is held by md_stall.
- Mult path:
  - At the edge ending cycle N: latch mul_a, mul_b, mul_signed; enter MUL; load counter with MUL_LAT.
  - mul_start is high in cycle N+1 only.
  - Counter decrements each cycle. In cycle N+1+MUL_LAT, mul_result is registered into wb_MD_result; state goes to DONE.
  - wb_MD_complete is high in cycle N+2+MUL_LAT.
- Div path:
  - At the edge ending cycle N: latch sign bits s1 and s2 (0 if unsigned) and operand magnitudes; clear the partial remainder; load counter with 32.
  - DIV runs one restoring iteration per cycle in cycles N+1..N+32.
  - SIGN is at N+33:
    - quotient negated if s1^s2;
    - remainder negated if s1.
  - DONE is at N+34.
  - Result: HI=remainder, LO=quotient.
- Divide by zero: no trap. LO=0xFFFFFFFF, HI=src1, using the normal 34-cycle timing.
- DONE: wb_MD_complete=1 for exactly one cycle; next state IDLE. A new request is accepted in the cycle after DONE.
- md_busy = (state != IDLE), combinational. It is high during DONE, so HI/LO reads wait until decode's HI/LO registers update.
- md_stall = md_busy & (de_md_read | de_mult_en | de_div_en).
- flush:
  - In MUL, DIV or SIGN: next state IDLE, no completion pulse; a late mul_result is discarded.
  - In IDLE: it blocks acceptance in that cycle.
  - In DONE: no effect, since the op is already committed.
- wb_MD_result holds its last value between operations.
- reset mid-operation: immediate IDLE, no completion pulse.

Optional Feature:
MD_EARLY_EXIT_EN
- Defined: if |divisor| > |dividend| and divisor != 0 at acceptance, skip DIV/SIGN and go directly to DONE with LO=0, HI=src1 (unmodified sign). wb_MD_complete is high in cycle N+2.
- Undefined: every divide takes the full 34-cycle path.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF, MUL_LAT=2, request cycle N -> mul_start at N+1; complete at N+4; result 0xFFFFFFFE_00000001.
- div signed -7 / 2 at cycle N -> complete at N+34; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 0 -> complete at N+34; LO=0xFFFFFFFF, HI=0x00000064.
- div issued at N, flush at N+10 -> no complete pulse; md_busy low from N+11; a mult at N+11 is accepted normally.
- de_md_read=1 continuously during a mult -> md_stall=1 from N+1 through the DONE cycle; 0 the cycle after.
- divu 3 / 10 -> with MD_EARLY_EXIT_EN: complete at N+2, HI=3, LO=0; without it: complete at N+34 with the same values.
